video_trans_eth_arp_tx: RTL and testbench
=========================================

VIDEO_TRANS_ETH_ARP_TX -- requirements
Module: video_trans_eth_arp_tx

Interface
REQ-001 SHALL have parameter BOARD_MAC, default 48'h00_11_22_33_44_55, local MAC used as sender MAC.
REQ-002 SHALL have parameter BOARD_IP, default 192.168.1.10, local IP used as sender IP.
REQ-003 SHALL have parameter DES_MAC, default 48'hff_ff_ff_ff_ff_ff, fallback peer MAC.
REQ-004 SHALL have parameter DES_IP, default 192.168.1.102, fallback peer IP.
REQ-005 SHALL have port clk  input  1  transmit clock; one clock domain only.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port arp_tx_en  input  1  single-cycle start pulse.
REQ-008 SHALL have port arp_tx_type  input  1  0 = ARP request, 1 = ARP reply.
REQ-009 SHALL have port des_mac  input  48  peer MAC; arp_rx src_mac connects here.
REQ-010 SHALL have port des_ip  input  32  peer IP; arp_rx src_ip connects here.
REQ-011 SHALL have port gmii_tx_en  output  1  GMII transmit enable.
REQ-012 SHALL have port gmii_txd  output  8  GMII transmit byte.
REQ-013 SHALL have port tx_done  output  1  one-cycle end-of-frame pulse.
REQ-014 SHALL have port busy  output  1  high from accept through end of IFG.

Function
REQ-015 SHALL accept arp_tx_en only when busy=0; arp_tx_en while busy=1 is ignored, with no queueing.
REQ-016 SHALL latch arp_tx_type, des_mac and des_ip on the accept cycle; later input changes SHALL NOT affect the frame.
REQ-017 SHALL substitute DES_MAC when latched des_mac==0, and DES_IP when latched des_ip==0.
REQ-018 SHALL implement FSM IDLE -> PREAMBLE -> ETH_HEAD -> ARP_DATA -> CRC -> IFG -> IDLE, with no other transitions except reset.
REQ-019 SHALL assert gmii_tx_en with the first byte on the cycle after the accept cycle.
REQ-020 SHALL hold gmii_tx_en high for exactly 72 consecutive cycles: 8 preamble/SFD, 60 header+payload, 4 FCS.
REQ-021 PREAMBLE SHALL send 0x55 seven times, then 0xD5.
REQ-022 ETH_HEAD SHALL send, byte by byte, MSB byte first:
- destination MAC: ff..ff for a request, the peer MAC for a reply;
- BOARD_MAC;
- type 0x0806.
REQ-023 ARP_DATA SHALL send 0x0001, 0x0800, 0x06, 0x04, then the opcode (0x0001 request, 0x0002 reply).
REQ-024 ARP_DATA SHALL then send BOARD_MAC, BOARD_IP, the target MAC (00..00 for a request, peer MAC for a reply), the peer IP, and 18 bytes of 0x00 padding.
REQ-025 SHALL compute CRC-32 over the 60 header+payload bytes only (not preamble/SFD):
- polynomial 0x04C11DB7, reflected, byte-wise;
- init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
REQ-026 CRC state SHALL send the 4 FCS bytes least-significant byte first, each byte bit-reflected per IEEE 802.3.
REQ-027 SHALL re-initialise the CRC to 0xFFFFFFFF in IDLE, so back-to-back frames are independent.
REQ-028 SHALL pulse tx_done high for exactly one cycle, on the first cycle after the last FCS byte, coincident with gmii_tx_en=0.
REQ-029 IFG SHALL hold gmii_tx_en=0 and gmii_txd=0 for 12 cycles, then return to IDLE with busy=0.
REQ-030 SHALL drive gmii_txd=0x00 whenever gmii_tx_en=0.
REQ-031 An arp_tx_en arriving on the same cycle busy deasserts SHALL be accepted.
REQ-032 gmii_tx_en, gmii_txd, tx_done and busy SHALL all be registered outputs.

Reset
REQ-033 rst_n low SHALL immediately force: FSM=IDLE, gmii_tx_en=0, gmii_txd=0x00, tx_done=0, busy=0, all byte counters=0, CRC=0xFFFFFFFF, latched fields=0.
REQ-034 Reset mid-frame SHALL truncate the frame immediately; no FCS and no tx_done SHALL follow.
REQ-035 After rst_n rises, the first arp_tx_en SHALL produce a complete, correct frame.

Verification
REQ-036 Request: arp_tx_type=0, des_ip=192.168.1.102 -> 72 enable cycles; bytes 8-13 = ff; bytes 28-29 = 00 01; bytes 46-49 = c0 a8 01 66; tx_done at cycle 73.
REQ-037 Reply: arp_tx_type=1, des_mac=a0:b1:c2:d3:e4:f5 -> bytes 8-13 and 40-45 = a0 b1 c2 d3 e4 f5; opcode bytes = 00 02.
REQ-038 FCS check: run the 60 bytes after SFD plus the 4 FCS bytes through a reference CRC-32 -> residue 0xC704DD7B; the FCS bytes match a software model.
REQ-039 Busy rejection: second arp_tx_en at enable cycle 30 and again during IFG -> exactly one frame; next pulse after busy=0 -> second identical frame with 12-cycle gap.
REQ-040 Zero peer: des_mac=0, des_ip=0, reply -> DES_MAC/DES_IP appear in destination and target fields.
REQ-041 Reset at enable cycle 40 -> gmii_tx_en=0 immediately, no tx_done; a subsequent request is correct.

Source files
------------

// File: rtl/video_trans_eth_arp_tx_if.sv
// ARP transmit request/status and GMII byte stream bundle.
// The master side issues requests; the slave side is the ARP transmitter.
interface video_trans_eth_arp_tx_if;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        tx_done;
    logic        busy;

    modport master (
        output arp_tx_en, arp_tx_type, des_mac, des_ip,
        input  gmii_tx_en, gmii_txd, tx_done, busy
    );

    modport slave (
        input  arp_tx_en, arp_tx_type, des_mac, des_ip,
        output gmii_tx_en, gmii_txd, tx_done, busy
    );
endinterface

// File: rtl/video_trans_eth_arp_tx.sv
// ARP request/reply frame generator on GMII: preamble, Ethernet header,
// ARP payload with padding, CRC-32 FCS, then a 12-cycle inter-frame gap.
module video_trans_eth_arp_tx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP    = {8'd192, 8'd168, 8'd1, 8'd102}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    video_trans_eth_arp_tx_if.slave       arp_if
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(13);
    localparam logic [CNT_W-1:0] ARP_LAST  = CNT_W'(45);
    localparam logic [CNT_W-1:0] FCS_LAST  = CNT_W'(3);
    localparam logic [CNT_W-1:0] IFG_LAST  = CNT_W'(11);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_ETH_HEAD, S_ARP_DATA, S_CRC, S_IFG
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic             type_q, type_d;
    logic [47:0]      mac_q, mac_d;
    logic [31:0]      ip_q, ip_d;
    logic             tx_en_q, tx_en_d;
    logic [7:0]       txd_q, txd_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [47:0] peer_mac;
    logic [31:0] peer_ip;
    logic [47:0] dst_mac;
    logic [47:0] tgt_mac;
    logic [31:0] fcs;

    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
        logic [47:0] s;
        s = m << {i, 3'b000};
        return s[47:40];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] i);
        logic [31:0] s;
        s = a << {i, 3'b000};
        return s[31:24];
    endfunction

    function automatic logic [7:0] head_byte(input logic [CNT_W-1:0] i, input logic [47:0] dst);
        if (i < CNT_W'(6))       return mac_byte(dst, 3'(i));
        else if (i < CNT_W'(12)) return mac_byte(BOARD_MAC, 3'(i - CNT_W'(6)));
        else if (i == CNT_W'(12)) return 8'h08;
        else                     return 8'h06;
    endfunction

    function automatic logic [7:0] arp_byte(input logic [CNT_W-1:0] i, input logic reply,
                                            input logic [47:0] tgt, input logic [31:0] pip);
        case (i)
            CNT_W'(0): return 8'h00;
            CNT_W'(1): return 8'h01;
            CNT_W'(2): return 8'h08;
            CNT_W'(3): return 8'h00;
            CNT_W'(4): return 8'h06;
            CNT_W'(5): return 8'h04;
            CNT_W'(6): return 8'h00;
            CNT_W'(7): return reply ? 8'h02 : 8'h01;
            default: begin
                if (i < CNT_W'(14))      return mac_byte(BOARD_MAC, 3'(i - CNT_W'(8)));
                else if (i < CNT_W'(18)) return ip_byte(BOARD_IP, 2'(i - CNT_W'(14)));
                else if (i < CNT_W'(24)) return mac_byte(tgt, 3'(i - CNT_W'(18)));
                else if (i < CNT_W'(28)) return ip_byte(pip, 2'(i - CNT_W'(24)));
                else                     return 8'h00;
            end
        endcase
    endfunction

    // Reflected CRC-32 (0xEDB88320 == bit-reversed 0x04C11DB7), LSB of byte first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign peer_mac = (mac_q == 48'd0) ? DES_MAC : mac_q;
    assign peer_ip  = (ip_q == 32'd0) ? DES_IP : ip_q;
    assign dst_mac  = type_q ? peer_mac : 48'hff_ff_ff_ff_ff_ff;
    assign tgt_mac  = type_q ? peer_mac : 48'd0;
    // The reflected register already holds FCS bits in wire order: bit 0 of each byte goes first.
    assign fcs      = ~crc_q;

    // Next-state sequencing, then the byte for the next cycle from (state_d, cnt_d).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        type_d  = type_q;
        mac_d   = mac_q;
        ip_d    = ip_q;
        busy_d  = busy_q;
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                crc_d  = 32'hFFFF_FFFF;
                busy_d = 1'b0;
                if (arp_if.arp_tx_en) begin
                    state_d = S_PREAMBLE;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    type_d  = arp_if.arp_tx_type;
                    mac_d   = arp_if.des_mac;
                    ip_d    = arp_if.des_ip;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin state_d = S_ETH_HEAD; cnt_d = '0; end
                else cnt_d = cnt_q + CNT_W'(1);
            end
            S_ETH_HEAD: begin
                if (cnt_q == HEAD_LAST) begin state_d = S_ARP_DATA; cnt_d = '0; end
                else cnt_d = cnt_q + CNT_W'(1);
            end
            S_ARP_DATA: begin
                if (cnt_q == ARP_LAST) begin state_d = S_CRC; cnt_d = '0; end
                else cnt_d = cnt_q + CNT_W'(1);
            end
            S_CRC: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        case (state_d)
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_d == PRE_LAST) ? 8'hD5 : 8'h55;
            end
            S_ETH_HEAD: begin
                tx_en_d = 1'b1;
                txd_d   = head_byte(cnt_d, dst_mac);
                crc_d   = crc_next(crc_q, txd_d);
            end
            S_ARP_DATA: begin
                tx_en_d = 1'b1;
                txd_d   = arp_byte(cnt_d, type_q, tgt_mac, peer_ip);
                crc_d   = crc_next(crc_q, txd_d);
            end
            S_CRC: begin
                tx_en_d = 1'b1;
                txd_d   = 8'(fcs >> {cnt_d[1:0], 3'b000});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            type_q  <= 1'b0;
            mac_q   <= '0;
            ip_q    <= '0;
            tx_en_q <= 1'b0;
            txd_q   <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            type_q  <= type_d;
            mac_q   <= mac_d;
            ip_q    <= ip_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign arp_if.gmii_tx_en = tx_en_q;
    assign arp_if.gmii_txd   = txd_q;
    assign arp_if.tx_done    = done_q;
    assign arp_if.busy       = busy_q;

endmodule

// File: tb/tb_video_trans_eth_arp_tx.sv
// Directed bench for the ARP transmitter: frame contents, FCS, timing,
// busy rejection, zero-peer fallback and mid-frame reset.
module tb_video_trans_eth_arp_tx;

    logic clk;
    logic rst_n;

    video_trans_eth_arp_tx_if arp ();

    video_trans_eth_arp_tx dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arp_if (arp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] cap [0:79];
    logic [7:0] exp_f [0:71];
    int cap_len, cap_first, cap_split, cap_done_n, cap_done_c, cap_bad, cap_ifg, cap_end;

    // Independent MSB-first CRC-32 (poly 0x04C11DB7), data bits fed LSB first.
    function automatic logic [31:0] crc_msb(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int j = 0; j < 8; j++) begin
            if (r[31] ^ d[j]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    task automatic build_exp(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        logic [47:0] pm, dst, tgt;
        logic [31:0] pi, r;
        logic [47:0] bmac;
        logic [31:0] bip;
        int k;
        bmac = 48'h00_11_22_33_44_55;
        bip  = 32'hc0_a8_01_0a;
        pm   = (mac == 48'd0) ? 48'hff_ff_ff_ff_ff_ff : mac;
        pi   = (ip == 32'd0) ? 32'hc0_a8_01_66 : ip;
        dst  = typ ? pm : 48'hff_ff_ff_ff_ff_ff;
        tgt  = typ ? pm : 48'd0;
        for (int i = 0; i < 7; i++) exp_f[i] = 8'h55;
        exp_f[7] = 8'hd5;
        k = 8;
        for (int i = 0; i < 6; i++) begin exp_f[k] = dst[47-8*i -: 8]; k++; end
        for (int i = 0; i < 6; i++) begin exp_f[k] = bmac[47-8*i -: 8]; k++; end
        exp_f[k] = 8'h08; exp_f[k+1] = 8'h06; k += 2;
        exp_f[k] = 8'h00; exp_f[k+1] = 8'h01; exp_f[k+2] = 8'h08; exp_f[k+3] = 8'h00;
        exp_f[k+4] = 8'h06; exp_f[k+5] = 8'h04; exp_f[k+6] = 8'h00;
        exp_f[k+7] = typ ? 8'h02 : 8'h01; k += 8;
        for (int i = 0; i < 6; i++) begin exp_f[k] = bmac[47-8*i -: 8]; k++; end
        for (int i = 0; i < 4; i++) begin exp_f[k] = bip[31-8*i -: 8]; k++; end
        for (int i = 0; i < 6; i++) begin exp_f[k] = tgt[47-8*i -: 8]; k++; end
        for (int i = 0; i < 4; i++) begin exp_f[k] = pi[31-8*i -: 8]; k++; end
        for (int i = 0; i < 18; i++) begin exp_f[k] = 8'h00; k++; end
        r = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) r = crc_msb(r, exp_f[i]);
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 8; j++) exp_f[68+b][j] = ~r[31-8*b-j];
    endtask

    // Issue one request from a negedge and record everything until busy drops.
    task automatic run_frame(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                             input int xa, input int xb);
        cap_len = 0; cap_first = 0; cap_split = 0; cap_done_n = 0; cap_done_c = 0;
        cap_bad = 0; cap_ifg = 0; cap_end = 0;
        arp.arp_tx_en   = 1'b1;
        arp.arp_tx_type = typ;
        arp.des_mac     = mac;
        arp.des_ip      = ip;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                arp.arp_tx_type = ~typ;
                arp.des_mac     = 48'h12_34_56_78_9a_bc;
                arp.des_ip      = 32'hde_ad_be_ef;
            end
            if (arp.gmii_tx_en) begin
                if (cap_len == 0) cap_first = c;
                else if (c != cap_first + cap_len) cap_split++;
                if (cap_len < 80) cap[cap_len] = arp.gmii_txd;
                cap_len++;
            end else begin
                if (arp.gmii_txd !== 8'h00) cap_bad++;
                if (arp.busy && cap_len > 0) cap_ifg++;
            end
            if (arp.tx_done) begin
                cap_done_n++;
                cap_done_c = c;
                if (arp.gmii_tx_en) cap_bad++;
            end
            arp.arp_tx_en = (c == xa || c == xb);
            if (!arp.busy) begin cap_end = c; break; end
        end
        arp.arp_tx_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        arp.arp_tx_en = 1'b0; arp.arp_tx_type = 1'b0; arp.des_mac = '0; arp.des_ip = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({arp.gmii_tx_en, arp.gmii_txd, arp.tx_done, arp.busy} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: en=%b txd=%h done=%b busy=%b, required all 0",
                     arp.gmii_tx_en, arp.gmii_txd, arp.tx_done, arp.busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({arp.gmii_tx_en, arp.busy} !== 2'b00) begin
            fails++;
            $display("FAIL idle_after_reset: en=%b busy=%b, required 0 0", arp.gmii_tx_en, arp.busy);
        end
    endtask

    task automatic test_request();
        int bi;
        build_exp(1'b0, 48'd0, 32'hc0_a8_01_66);
        run_frame(1'b0, 48'd0, 32'hc0_a8_01_66, 0, 0);
        tests++;
        if (cap_first != 1 || cap_len != 72 || cap_split != 0) begin
            fails++;
            $display("FAIL req_enable_window: first=%0d len=%0d split=%0d, required 1 72 0",
                     cap_first, cap_len, cap_split);
        end
        tests++;
        if (cap_done_n != 1 || cap_done_c != 73) begin
            fails++;
            $display("FAIL req_tx_done: pulses=%0d at=%0d, required 1 at 73", cap_done_n, cap_done_c);
        end
        tests++;
        if ({cap[8], cap[9], cap[10], cap[11], cap[12], cap[13]} !== 48'hff_ff_ff_ff_ff_ff) begin
            fails++;
            $display("FAIL req_dst_mac: got %h%h%h%h%h%h, required ffffffffffff",
                     cap[8], cap[9], cap[10], cap[11], cap[12], cap[13]);
        end
        tests++;
        if ({cap[28], cap[29]} !== 16'h0001) begin
            fails++;
            $display("FAIL req_opcode: got %h%h, required 0001", cap[28], cap[29]);
        end
        tests++;
        if ({cap[46], cap[47], cap[48], cap[49]} !== 32'hc0_a8_01_66) begin
            fails++;
            $display("FAIL req_target_ip: got %h%h%h%h, required c0a80166",
                     cap[46], cap[47], cap[48], cap[49]);
        end
        bi = -1;
        for (int i = 0; i < 72; i++) if (cap[i] !== exp_f[i] && bi < 0) bi = i;
        tests++;
        if (bi >= 0) begin
            fails++;
            $display("FAIL req_frame: byte %0d got %h, required %h", bi, cap[bi], exp_f[bi]);
        end
        tests++;
        if (cap_end != 85 || cap_bad != 0 || cap_ifg != 12) begin
            fails++;
            $display("FAIL req_ifg: busy_low_at=%0d bad_idle=%0d ifg=%0d, required 85 0 12",
                     cap_end, cap_bad, cap_ifg);
        end
    endtask

    task automatic test_fcs();
        logic [31:0] r;
        build_exp(1'b0, 48'd0, 32'h0a_00_00_07);
        run_frame(1'b0, 48'd0, 32'h0a_00_00_07, 0, 0);
        r = 32'hFFFF_FFFF;
        for (int i = 8; i < 72; i++) r = crc_msb(r, cap[i]);
        tests++;
        if (r !== 32'hC704_DD7B) begin
            fails++;
            $display("FAIL fcs_residue: got %h, required c704dd7b", r);
        end
        tests++;
        if ({cap[68], cap[69], cap[70], cap[71]} !== {exp_f[68], exp_f[69], exp_f[70], exp_f[71]}) begin
            fails++;
            $display("FAIL fcs_bytes: got %h%h%h%h, required %h%h%h%h", cap[68], cap[69], cap[70],
                     cap[71], exp_f[68], exp_f[69], exp_f[70], exp_f[71]);
        end
    endtask

    task automatic test_reply();
        int bi;
        build_exp(1'b1, 48'ha0_b1_c2_d3_e4_f5, 32'hc0_a8_01_66);
        run_frame(1'b1, 48'ha0_b1_c2_d3_e4_f5, 32'hc0_a8_01_66, 0, 0);
        tests++;
        if ({cap[8], cap[9], cap[10], cap[11], cap[12], cap[13]} !== 48'ha0_b1_c2_d3_e4_f5) begin
            fails++;
            $display("FAIL rep_dst_mac: got %h%h%h%h%h%h, required a0b1c2d3e4f5",
                     cap[8], cap[9], cap[10], cap[11], cap[12], cap[13]);
        end
        tests++;
        if ({cap[40], cap[41], cap[42], cap[43], cap[44], cap[45]} !== 48'ha0_b1_c2_d3_e4_f5) begin
            fails++;
            $display("FAIL rep_tgt_mac: got %h%h%h%h%h%h, required a0b1c2d3e4f5",
                     cap[40], cap[41], cap[42], cap[43], cap[44], cap[45]);
        end
        tests++;
        if ({cap[28], cap[29]} !== 16'h0002) begin
            fails++;
            $display("FAIL rep_opcode: got %h%h, required 0002", cap[28], cap[29]);
        end
        bi = -1;
        for (int i = 0; i < 72; i++) if (cap[i] !== exp_f[i] && bi < 0) bi = i;
        tests++;
        if (bi >= 0 || cap_len != 72) begin
            fails++;
            $display("FAIL rep_frame: len=%0d byte %0d mismatch, required len 72 and model bytes",
                     cap_len, bi);
        end
    endtask

    task automatic test_back_to_back();
        int bi;
        build_exp(1'b0, 48'd0, 32'hc0_a8_01_66);
        run_frame(1'b0, 48'd0, 32'hc0_a8_01_66, 30, 78);
        tests++;
        if (cap_len != 72 || cap_done_n != 1 || cap_ifg != 12 || cap_end != 85) begin
            fails++;
            $display("FAIL busy_reject: len=%0d done=%0d ifg=%0d end=%0d, required 72 1 12 85",
                     cap_len, cap_done_n, cap_ifg, cap_end);
        end
        run_frame(1'b0, 48'd0, 32'hc0_a8_01_66, 0, 0);
        tests++;
        if (cap_first != 1 || cap_len != 72 || cap_done_c != 73) begin
            fails++;
            $display("FAIL b2b_timing: first=%0d len=%0d done_at=%0d, required 1 72 73",
                     cap_first, cap_len, cap_done_c);
        end
        bi = -1;
        for (int i = 0; i < 72; i++) if (cap[i] !== exp_f[i] && bi < 0) bi = i;
        tests++;
        if (bi >= 0) begin
            fails++;
            $display("FAIL b2b_frame: byte %0d got %h, required %h", bi, cap[bi], exp_f[bi]);
        end
    endtask

    task automatic test_zero_peer();
        int bi;
        build_exp(1'b1, 48'd0, 32'd0);
        run_frame(1'b1, 48'd0, 32'd0, 0, 0);
        tests++;
        if ({cap[8], cap[9], cap[10], cap[11], cap[12], cap[13], cap[46], cap[47], cap[48], cap[49]}
            !== 80'hff_ff_ff_ff_ff_ff_c0_a8_01_66) begin
            fails++;
            $display("FAIL zero_peer_fields: dst=%h%h%h%h%h%h ip=%h%h%h%h, required ffffffffffff c0a80166",
                     cap[8], cap[9], cap[10], cap[11], cap[12], cap[13], cap[46], cap[47], cap[48], cap[49]);
        end
        bi = -1;
        for (int i = 0; i < 72; i++) if (cap[i] !== exp_f[i] && bi < 0) bi = i;
        tests++;
        if (bi >= 0 || cap_len != 72) begin
            fails++;
            $display("FAIL zero_peer_frame: len=%0d byte %0d mismatch, required len 72 and model bytes",
                     cap_len, bi);
        end
    endtask

    task automatic test_reset_mid_frame();
        int seen, bi;
        arp.arp_tx_en = 1'b1; arp.arp_tx_type = 1'b0; arp.des_mac = '0; arp.des_ip = 32'hc0_a8_01_66;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            arp.arp_tx_en = 1'b0;
        end
        tests++;
        if (arp.gmii_tx_en !== 1'b1) begin
            fails++;
            $display("FAIL mid_frame_active: en=%b at enable cycle 40, required 1", arp.gmii_tx_en);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({arp.gmii_tx_en, arp.gmii_txd, arp.tx_done, arp.busy} !== 11'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: en=%b txd=%h done=%b busy=%b, required all 0",
                     arp.gmii_tx_en, arp.gmii_txd, arp.tx_done, arp.busy);
        end
        seen = 0;
        repeat (4) begin @(negedge clk); if (arp.gmii_tx_en || arp.tx_done) seen++; end
        rst_n = 1'b1;
        repeat (100) begin @(negedge clk); if (arp.gmii_tx_en || arp.tx_done || arp.busy) seen++; end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_reset_truncate: %0d active cycles after reset, required 0", seen);
        end
        build_exp(1'b0, 48'd0, 32'hc0_a8_01_66);
        run_frame(1'b0, 48'd0, 32'hc0_a8_01_66, 0, 0);
        bi = -1;
        for (int i = 0; i < 72; i++) if (cap[i] !== exp_f[i] && bi < 0) bi = i;
        tests++;
        if (bi >= 0 || cap_len != 72 || cap_done_c != 73) begin
            fails++;
            $display("FAIL post_reset_frame: len=%0d done_at=%0d bad_byte=%0d, required 72 73 -1",
                     cap_len, cap_done_c, bi);
        end
    endtask

    initial begin
        test_reset();
        test_request();
        test_fcs();
        test_reply();
        test_back_to_back();
        test_zero_peer();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
